// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit timing is derived from the shared 16x oversampled baud tick.
module uart_tx #(
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);
  localparam logic       STOP_LAST = (STOP_BITS == 2);
  localparam logic       ODD_BIT   = (PARITY_ODD != 0);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);

  state_t     state, state_d;
  logic [3:0] tick_cnt, tick_cnt_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] shift_reg, shift_d;
  logic       par, par_d;
  logic       stop_cnt, stop_cnt_d;
  logic       tx_d, busy_d, done_d;
  logic       bit_end;

  assign bit_end = b_tick && (tick_cnt == TICK_LAST);

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par       <= 1'b0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_cnt_d;
      bit_cnt   <= bit_cnt_d;
      shift_reg <= shift_d;
      par       <= par_d;
      stop_cnt  <= stop_cnt_d;
      tx        <= tx_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
    end
  end

  // next-state; an accept in IDLE swallows a coincident b_tick
  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_reg;
    par_d      = par;
    stop_cnt_d = stop_cnt;
    if (state != IDLE && b_tick)
      tick_cnt_d = bit_end ? 4'd0 : tick_cnt + 4'd1;
    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_d    = tx_data;
          par_d      = (^tx_data) ^ ODD_BIT;
          tick_cnt_d = 4'd0;
          stop_cnt_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d   = shift_reg >> 1;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_d = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end)
          state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            stop_cnt_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs are computed from the upcoming state so they register in step with it
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && (state_d == IDLE);
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter variants, a loopback receiver monitor and an expectation queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic [3:0] start = 4'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] tx_w, busy_w, done_w;

  int checks = 0;
  int failures = 0;
  int ticks = 0;
  int done_cnt [4] = '{0, 0, 0, 0};

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       par;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      n++;
      b_tick = (n % 4 == 0);
    end
  end

  always @(posedge clk) if (b_tick) ticks <= ticks + 1;

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;

  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .TICKS_PER_BIT(16)) u0 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start[0]), .tx_data(tx_data),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .TICKS_PER_BIT(16)) u1 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start[1]), .tx_data(tx_data),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .TICKS_PER_BIT(16)) u2 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start[2]), .tx_data(tx_data),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .TICKS_PER_BIT(16)) u3 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .tx_start(start[3]), .tx_data(tx_data),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int npar(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  // receiver model: samples each bit at its centre, counted in b_ticks from the start edge
  task automatic mon(input int i);
    int         t0, nbits, n;
    logic       bits [12];
    logic [7:0] data;
    logic       busy_bad, aborted, stop_ok;
    exp_t       e;
    forever begin
      while (!(rst && tx_w[i] == 1'b0)) @(negedge clk);
      t0       = ticks;
      nbits    = 9 + npar(i) + nstop(i);
      busy_bad = 1'b0;
      aborted  = 1'b0;
      for (int k = 0; k < nbits && !aborted; k++) begin
        while (ticks < t0 + 16 * k + 8 && !aborted) begin
          @(negedge clk);
          if (!rst) aborted = 1'b1;
        end
        bits[k] = tx_w[i];
        if (!busy_w[i]) busy_bad = 1'b1;
      end
      n = 0;
      while (!aborted && !done_w[i] && n < 400) begin
        @(negedge clk);
        n++;
        if (!rst) aborted = 1'b1;
      end
      if (!aborted) begin
        check($sformatf("u%0d_frame_ticks", i), ticks - t0, 16 * nbits);
        check($sformatf("u%0d_busy_low_at_done", i), busy_w[i], 1'b0);
        check($sformatf("u%0d_busy_in_frame", i), busy_bad, 1'b0);
        for (int b = 0; b < 8; b++) data[b] = bits[1 + b];
        stop_ok = 1'b1;
        for (int s = 0; s < nstop(i); s++) if (bits[9 + npar(i) + s] !== 1'b1) stop_ok = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL u%0d_unexpected_frame: got data %0h expected no frame", i, data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("u%0d_frame_owner", i), i, e.idx);
          check($sformatf("u%0d_start_bit", i), bits[0], 1'b0);
          check($sformatf("u%0d_data", i), data, e.data);
          if (npar(i) != 0) check($sformatf("u%0d_parity", i), bits[9], e.par);
          check($sformatf("u%0d_stop_bits", i), stop_ok, 1'b1);
        end
        @(negedge clk);
        check($sformatf("u%0d_done_width", i), done_w[i], 1'b0);
      end
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial mon(g);
  end

  task automatic pulse(input int i, input logic [7:0] d);
    tx_data  = d;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic p);
    exp_t e;
    e.idx  = i;
    e.data = d;
    e.par  = p;
    exp_q.push_back(e);
    pulse(i, d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_w != 4'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, (n < 3000), 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic quiet(input string name, input int cycles);
    logic bad = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_w != 4'hF || busy_w != 4'h0 || done_w != 4'h0) bad = 1'b1;
    end
    check(name, bad, 1'b0);
  endtask

  initial begin
    int n;
    int d0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_w, 4'hF);
    check("reset_busy", busy_w, 4'h0);
    check("reset_done", done_w, 4'h0);
    rst = 1'b1;
    quiet("idle_no_request", 200);

    send(0, 8'h55, 1'b0);
    wait_idle("send_55");
    send(1, 8'h07, 1'b1);
    wait_idle("par_even_07");
    send(2, 8'h07, 1'b0);
    wait_idle("par_odd_07");
    send(3, 8'hA3, 1'b0);
    wait_idle("stop2_A3");

    // request while busy must not disturb or queue behind the frame in flight
    d0 = done_cnt[0];
    send(0, 8'h00, 1'b0);
    repeat (300) @(negedge clk);
    pulse(0, 8'hFF);
    wait_idle("busy_ignore");
    quiet("no_second_frame", 800);
    check("busy_ignore_done_pulses", done_cnt[0] - d0, 1);

    // back-to-back: request raised in the done cycle
    d0 = done_cnt[0];
    send(0, 8'h00, 1'b0);
    n = 0;
    while (!done_w[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", done_w[0], 1'b1);
    send(0, 8'h3C, 1'b0);
    check("b2b_start_next_clk", tx_w[0], 1'b0);
    check("b2b_busy_next_clk", busy_w[0], 1'b1);
    wait_idle("b2b");
    check("b2b_done_pulses", done_cnt[0] - d0, 2);

    // reset mid-frame
    pulse(0, 8'h55);
    repeat (200) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_tx", tx_w[0], 1'b1);
    check("async_reset_busy", busy_w[0], 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    quiet("no_resume_after_reset", 800);

    check("total_done_u0", done_cnt[0], 4);
    check("total_done_u1", done_cnt[1], 1);
    check("total_done_u2", done_cnt[2], 1);
    check("total_done_u3", done_cnt[3], 1);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
